// File: rtl/param_proc_core.sv
`default_nettype none
// ============================================================================
//  Module   : param_proc_core
//  Brief    : Parametrised multi-cycle processor core. 32-bit instructions,
//             configurable data width, register count, memory depths and
//             post-execute delay; program-load port and run/halt handshake.
//  Revision : 1.0  initial release
// ============================================================================
module param_proc_core #(
    parameter int DATA_W     = 16,
    parameter int NGPR       = 32,
    parameter int IMEM_AW    = 4,
    parameter int DMEM_AW    = 4,
    parameter int EXEC_DELAY = 4
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               run,
    input  logic [DATA_W-1:0]  din,
    input  logic               imem_we,
    input  logic [IMEM_AW-1:0] imem_waddr,
    input  logic [31:0]        imem_wdata,
    output logic [DATA_W-1:0]  dout,
    output logic               dout_valid,
    output logic               halted,
    output logic [IMEM_AW-1:0] pc_out,
    output logic [3:0]         flags_out
);

    localparam int RIDX_W = (NGPR > 1) ? $clog2(NGPR) : 1;
    localparam int PROD_W = 2 * DATA_W;
    // Value loaded into the delay counter on leaving EXEC (counts down to 0)
    localparam logic [3:0] c_DLY_LAST = (EXEC_DELAY > 0) ? 4'(EXEC_DELAY - 1) : 4'd0;

    // FSM encoding
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FETCH = 3'd1;
    localparam logic [2:0] c_EXEC  = 3'd2;
    localparam logic [2:0] c_DELAY = 3'd3;
    localparam logic [2:0] c_NEXT  = 3'd4;
    localparam logic [2:0] c_HALT  = 3'd5;

    // Opcode map
    localparam logic [4:0] c_OP_MOVSGPR  = 5'b00000;
    localparam logic [4:0] c_OP_MOV      = 5'b00001;
    localparam logic [4:0] c_OP_ADD      = 5'b00010;
    localparam logic [4:0] c_OP_SUB      = 5'b00011;
    localparam logic [4:0] c_OP_MUL      = 5'b00100;
    localparam logic [4:0] c_OP_ROR      = 5'b00101;
    localparam logic [4:0] c_OP_RAND     = 5'b00110;
    localparam logic [4:0] c_OP_RXOR     = 5'b00111;
    localparam logic [4:0] c_OP_RXNOR    = 5'b01000;
    localparam logic [4:0] c_OP_RNAND    = 5'b01001;
    localparam logic [4:0] c_OP_RNOR     = 5'b01010;
    localparam logic [4:0] c_OP_RNOT     = 5'b01011;
    localparam logic [4:0] c_OP_STOREREG = 5'b01101;
    localparam logic [4:0] c_OP_STOREDIN = 5'b01110;
    localparam logic [4:0] c_OP_SENDDOUT = 5'b01111;
    localparam logic [4:0] c_OP_SENDREG  = 5'b10001;
    localparam logic [4:0] c_OP_JUMP     = 5'b10010;
    localparam logic [4:0] c_OP_JCARRY   = 5'b10011;
    localparam logic [4:0] c_OP_JNOCARRY = 5'b10100;
    localparam logic [4:0] c_OP_JSIGN    = 5'b10101;
    localparam logic [4:0] c_OP_JNOSIGN  = 5'b10110;
    localparam logic [4:0] c_OP_JZERO    = 5'b10111;
    localparam logic [4:0] c_OP_JNOZERO  = 5'b11000;
    localparam logic [4:0] c_OP_JOVF     = 5'b11001;
    localparam logic [4:0] c_OP_JNOOVF   = 5'b11010;
    localparam logic [4:0] c_OP_HALT     = 5'b11011;

    // Architectural state
    logic [2:0]         r_state_q,      w_state_d;
    logic [IMEM_AW-1:0] r_pc_q,         w_pc_d;
    logic [31:0]        r_ir_q,         w_ir_d;
    logic [DATA_W-1:0]  r_sgpr_q,       w_sgpr_d;
    logic [3:0]         r_flags_q,      w_flags_d;     // {sign, zero, overflow, carry}
    logic [DATA_W-1:0]  r_dout_q,       w_dout_d;
    logic               r_dout_valid_q, w_dout_valid_d;
    logic               r_jump_q,       w_jump_d;
    logic [3:0]         r_dcnt_q,       w_dcnt_d;

    logic [DATA_W-1:0]  r_gpr_q  [NGPR];
    logic [31:0]        r_imem_q [2**IMEM_AW];
    logic [DATA_W-1:0]  r_dmem_q [2**DMEM_AW];

    // Register-file and data-memory write ports
    logic               w_gpr_we;
    logic [DATA_W-1:0]  w_gpr_wdata;
    logic               w_dmem_we;
    logic [DATA_W-1:0]  w_dmem_wdata;

    // Instruction field decode
    logic [4:0]         w_op;
    logic [RIDX_W-1:0]  w_rdst, w_rsrc1, w_rsrc2;
    logic               w_imm;
    logic [DATA_W-1:0]  w_isrc;
    logic [DMEM_AW-1:0] w_daddr;
    logic [IMEM_AW-1:0] w_jtgt;

    assign w_op    = r_ir_q[31:27];
    assign w_rdst  = r_ir_q[22 +: RIDX_W];
    assign w_rsrc1 = r_ir_q[17 +: RIDX_W];
    assign w_imm   = r_ir_q[16];
    assign w_rsrc2 = r_ir_q[11 +: RIDX_W];
    assign w_isrc  = DATA_W'(r_ir_q[15:0]);
    assign w_daddr = r_ir_q[DMEM_AW-1:0];
    assign w_jtgt  = r_ir_q[IMEM_AW-1:0];

    // Datapath operands and arithmetic results
    logic [DATA_W-1:0]  w_opa, w_opb, w_mem_rd;
    logic [DATA_W:0]    w_sum, w_diff;
    logic [PROD_W-1:0]  w_prod;

    assign w_opa    = r_gpr_q[w_rsrc1];
    assign w_opb    = w_imm ? w_isrc : r_gpr_q[w_rsrc2];
    assign w_sum    = {1'b0, w_opa} + {1'b0, w_opb};
    assign w_diff   = {1'b0, w_opa} - {1'b0, w_opb};
    assign w_prod   = PROD_W'(w_opa) * PROD_W'(w_opb);
    assign w_mem_rd = r_dmem_q[w_daddr];

    logic               w_is_alu;
    logic [DATA_W-1:0]  w_alu_res;
    logic               w_alu_c, w_alu_v, w_alu_s, w_alu_z;

    assign w_is_alu = (w_op <= c_OP_RNOT);

    // ALU: result plus carry/overflow; mul reports sign/zero on the full product
    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (w_op)
            c_OP_MOVSGPR: w_alu_res = r_sgpr_q;
            c_OP_MOV:     w_alu_res = w_imm ? w_isrc : w_opa;
            c_OP_ADD: begin
                w_alu_res = w_sum[DATA_W-1:0];
                w_alu_c   = w_sum[DATA_W];
                w_alu_v   = (w_opa[DATA_W-1] == w_opb[DATA_W-1]) &&
                            (w_alu_res[DATA_W-1] != w_opa[DATA_W-1]);
            end
            c_OP_SUB: begin
                w_alu_res = w_diff[DATA_W-1:0];
                w_alu_c   = w_diff[DATA_W];
                w_alu_v   = (w_opa[DATA_W-1] != w_opb[DATA_W-1]) &&
                            (w_alu_res[DATA_W-1] != w_opa[DATA_W-1]);
            end
            c_OP_MUL:     w_alu_res = w_prod[DATA_W-1:0];
            c_OP_ROR:     w_alu_res = w_opa | w_opb;
            c_OP_RAND:    w_alu_res = w_opa & w_opb;
            c_OP_RXOR:    w_alu_res = w_opa ^ w_opb;
            c_OP_RXNOR:   w_alu_res = ~(w_opa ^ w_opb);
            c_OP_RNAND:   w_alu_res = ~(w_opa & w_opb);
            c_OP_RNOR:    w_alu_res = ~(w_opa | w_opb);
            c_OP_RNOT:    w_alu_res = w_imm ? ~w_isrc : ~w_opa;
            default:      w_alu_res = '0;
        endcase
        w_alu_s = (w_op == c_OP_MUL) ? w_prod[PROD_W-1] : w_alu_res[DATA_W-1];
        w_alu_z = (w_op == c_OP_MUL) ? (w_prod == '0) : (w_alu_res == '0);
    end

    // Sequencer: next-state, register/memory write ports and jump decision
    always_comb begin
        w_state_d      = r_state_q;
        w_pc_d         = r_pc_q;
        w_ir_d         = r_ir_q;
        w_sgpr_d       = r_sgpr_q;
        w_flags_d      = r_flags_q;
        w_dout_d       = r_dout_q;
        w_dout_valid_d = 1'b0;
        w_jump_d       = r_jump_q;
        w_dcnt_d       = r_dcnt_q;
        w_gpr_we       = 1'b0;
        w_gpr_wdata    = w_alu_res;
        w_dmem_we      = 1'b0;
        w_dmem_wdata   = w_opa;
        case (r_state_q)
            c_IDLE, c_HALT: begin
                if (run) w_state_d = c_FETCH;
            end
            c_FETCH: begin
                w_ir_d    = r_imem_q[r_pc_q];
                w_state_d = c_EXEC;
            end
            c_EXEC: begin
                if (w_is_alu) begin
                    w_gpr_we  = 1'b1;
                    w_flags_d = {w_alu_s, w_alu_z, w_alu_v, w_alu_c};
                    if (w_op == c_OP_MUL) w_sgpr_d = w_prod[PROD_W-1:DATA_W];
                end
                case (w_op)
                    c_OP_STOREREG: w_dmem_we = 1'b1;
                    c_OP_STOREDIN: begin
                        w_dmem_we    = 1'b1;
                        w_dmem_wdata = din;
                    end
                    c_OP_SENDDOUT: begin
                        w_dout_d       = w_mem_rd;
                        w_dout_valid_d = 1'b1;
                    end
                    c_OP_SENDREG: begin
                        w_gpr_we    = 1'b1;
                        w_gpr_wdata = w_mem_rd;
                    end
                    default: ;
                endcase
                case (w_op)
                    c_OP_JUMP:     w_jump_d = 1'b1;
                    c_OP_JCARRY:   w_jump_d = r_flags_q[0];
                    c_OP_JNOCARRY: w_jump_d = ~r_flags_q[0];
                    c_OP_JSIGN:    w_jump_d = r_flags_q[3];
                    c_OP_JNOSIGN:  w_jump_d = ~r_flags_q[3];
                    c_OP_JZERO:    w_jump_d = r_flags_q[2];
                    c_OP_JNOZERO:  w_jump_d = ~r_flags_q[2];
                    c_OP_JOVF:     w_jump_d = r_flags_q[1];
                    c_OP_JNOOVF:   w_jump_d = ~r_flags_q[1];
                    default:       w_jump_d = 1'b0;
                endcase
                w_dcnt_d  = c_DLY_LAST;
                w_state_d = (EXEC_DELAY == 0) ? c_NEXT : c_DELAY;
            end
            c_DELAY: begin
                if (r_dcnt_q == 4'd0) w_state_d = c_NEXT;
                else                  w_dcnt_d  = r_dcnt_q - 4'd1;
            end
            c_NEXT: begin
                w_pc_d    = r_jump_q ? w_jtgt : r_pc_q + 1'b1;
                w_state_d = (w_op == c_OP_HALT) ? c_HALT : c_FETCH;
            end
            default: w_state_d = c_IDLE;
        endcase
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_state_q      <= c_IDLE;
            r_pc_q         <= '0;
            r_ir_q         <= '0;
            r_sgpr_q       <= '0;
            r_flags_q      <= '0;
            r_dout_q       <= '0;
            r_dout_valid_q <= 1'b0;
            r_jump_q       <= 1'b0;
            r_dcnt_q       <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_pc_q         <= w_pc_d;
            r_ir_q         <= w_ir_d;
            r_sgpr_q       <= w_sgpr_d;
            r_flags_q      <= w_flags_d;
            r_dout_q       <= w_dout_d;
            r_dout_valid_q <= w_dout_valid_d;
            r_jump_q       <= w_jump_d;
            r_dcnt_q       <= w_dcnt_d;
        end
    end

    // General-purpose register file, cleared by reset
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            for (int i = 0; i < NGPR; i++) r_gpr_q[i] <= '0;
        end else if (w_gpr_we) begin
            r_gpr_q[w_rdst] <= w_gpr_wdata;
        end
    end

    // Instruction and data memories keep their contents across reset
    always_ff @(posedge clk) begin
        if (!sys_rst && imem_we && (r_state_q == c_IDLE || r_state_q == c_HALT))
            r_imem_q[imem_waddr] <= imem_wdata;
        if (!sys_rst && w_dmem_we)
            r_dmem_q[w_daddr] <= w_dmem_wdata;
    end

    assign dout       = r_dout_q;
    assign dout_valid = r_dout_valid_q;
    assign halted     = (r_state_q == c_HALT);
    assign pc_out     = r_pc_q;
    assign flags_out  = r_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_param_proc_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_proc_core
//  Brief    : Directed testbench for param_proc_core with a dout scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_param_proc_core;

    localparam logic [4:0] MOVSGPR  = 5'b00000;
    localparam logic [4:0] MOV      = 5'b00001;
    localparam logic [4:0] ADD      = 5'b00010;
    localparam logic [4:0] SUB      = 5'b00011;
    localparam logic [4:0] MUL      = 5'b00100;
    localparam logic [4:0] STOREREG = 5'b01101;
    localparam logic [4:0] SENDDOUT = 5'b01111;
    localparam logic [4:0] JUMP     = 5'b10010;
    localparam logic [4:0] JZERO    = 5'b10111;
    localparam logic [4:0] HALT     = 5'b11011;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        run = 1'b0;
    logic [15:0] din = 16'h0;
    logic        imem_we = 1'b0;
    logic [3:0]  imem_waddr = 4'h0;
    logic [31:0] imem_wdata = 32'h0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        halted;
    logic [3:0]  pc_out;
    logic [3:0]  flags_out;

    int          total = 0;
    int          bad = 0;
    int          cyc;
    logic [15:0] exp_q [$];
    logic [15:0] mon_exp;

    param_proc_core dut (
        .clk        (clk),
        .sys_rst    (sys_rst),
        .run        (run),
        .din        (din),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .dout       (dout),
        .dout_valid (dout_valid),
        .halted     (halted),
        .pc_out     (pc_out),
        .flags_out  (flags_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ii(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [15:0] isrc);
        return {op, rd, rs1, 1'b1, isrc};
    endfunction

    function automatic logic [31:0] rr(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, 1'b0, rs2, 11'h0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] w);
        @(negedge clk);
        imem_we    = 1'b1;
        imem_waddr = a;
        imem_wdata = w;
        @(negedge clk);
        imem_we    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
    endtask

    // Leaves the bench just after the edge that moved the core into FETCH
    task automatic pulse_run();
        @(negedge clk);
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
    endtask

    task automatic wait_halt(input int maxc, output int n);
        n = 0;
        while (halted !== 1'b1 && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (halted !== 1'b1) begin
            total++;
            bad++;
            $error("FAIL halt_timeout: observed=halted=%b expected=1", halted);
        end
    endtask

    // Scoreboard: every dout_valid pulse must match the oldest expected value
    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL dout_unexpected: observed=%0h expected=none", dout);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("dout", 32'(dout), 32'(mon_exp));
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        sys_rst = 1'b0;

        // Reset state
        #1;
        chk("rst_pc",     32'(pc_out),     32'h0);
        chk("rst_halted", 32'(halted),     32'h0);
        chk("rst_dout",   32'(dout),       32'h0);
        chk("rst_dvalid", 32'(dout_valid), 32'h0);
        chk("rst_flags",  32'(flags_out),  32'h0);

        // Test 1: basic program, latency
        load(0, ii(MOV, 1, 0, 16'd5));
        load(1, ii(ADD, 2, 1, 16'd3));
        load(2, ii(STOREREG, 0, 2, 16'd2));
        load(3, ii(SENDDOUT, 0, 0, 16'd2));
        load(4, ii(HALT, 0, 0, 0));
        exp_q.push_back(16'h0008);
        pulse_run();
        wait_halt(200, cyc);
        chk("t1_cycles", 32'(cyc), 32'd35);
        chk("t1_pc",     32'(pc_out), 32'd5);
        chk("t1_flags",  32'(flags_out), 32'h0);
        chk("t1_dout_hold", 32'(dout), 32'h8);

        // Test 2: add carry-out to zero
        do_reset();
        load(0, ii(MOV, 1, 0, 16'hFFFF));
        load(1, ii(ADD, 2, 1, 16'h0001));
        load(2, ii(HALT, 0, 0, 0));
        pulse_run();
        wait_halt(200, cyc);
        chk("t2_flags_add", 32'(flags_out), 32'b0101);
        load(3, ii(STOREREG, 0, 2, 16'd0));
        load(4, ii(SENDDOUT, 0, 0, 16'd0));
        load(5, ii(HALT, 0, 0, 0));
        exp_q.push_back(16'h0000);
        pulse_run();
        wait_halt(200, cyc);
        chk("t2_flags_kept", 32'(flags_out), 32'b0101);
        chk("t2_pc", 32'(pc_out), 32'd6);

        // Test 3: signed overflow, then register-form subtract with borrow
        do_reset();
        load(0, ii(MOV, 1, 0, 16'h7FFF));
        load(1, ii(ADD, 2, 1, 16'h0001));
        load(2, ii(HALT, 0, 0, 0));
        pulse_run();
        wait_halt(200, cyc);
        chk("t3_flags_ovf", 32'(flags_out), 32'b1010);
        load(3, ii(STOREREG, 0, 2, 16'd1));
        load(4, ii(SENDDOUT, 0, 0, 16'd1));
        load(5, ii(MOV, 4, 0, 16'h8000));
        load(6, rr(SUB, 3, 1, 4));
        load(7, ii(HALT, 0, 0, 0));
        exp_q.push_back(16'h8000);
        pulse_run();
        wait_halt(200, cyc);
        chk("t3_flags_sub", 32'(flags_out), 32'b1011);

        // Test 4: multiply high half through SGPR
        do_reset();
        load(0, ii(MOV, 1, 0, 16'h0100));
        load(1, ii(MUL, 2, 1, 16'h0100));
        load(2, ii(HALT, 0, 0, 0));
        pulse_run();
        wait_halt(200, cyc);
        chk("t4_flags_mul", 32'(flags_out), 32'b0000);
        load(3, ii(STOREREG, 0, 2, 16'd3));
        load(4, ii(SENDDOUT, 0, 0, 16'd3));
        load(5, ii(MOVSGPR, 3, 0, 0));
        load(6, ii(STOREREG, 0, 3, 16'd4));
        load(7, ii(SENDDOUT, 0, 0, 16'd4));
        load(8, ii(HALT, 0, 0, 0));
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        pulse_run();
        wait_halt(200, cyc);
        chk("t4_flags_movsgpr", 32'(flags_out), 32'b0000);
        chk("t4_pc", 32'(pc_out), 32'd9);

        // Test 5: PC wrap, conditional jump both ways, load ignored while running
        do_reset();
        load(0,  ii(JUMP, 0, 0, 16'd13));
        load(13, ii(MOV, 1, 0, 16'd0));
        load(14, ii(MOV, 4, 0, 16'd0));
        load(15, ii(HALT, 0, 0, 0));
        pulse_run();
        wait_halt(200, cyc);
        chk("t5_pc_wrap", 32'(pc_out), 32'd0);
        chk("t5_flags_zero", 32'(flags_out), 32'b0100);
        load(0, ii(JZERO, 0, 0, 16'd3));
        load(3, ii(HALT, 0, 0, 0));
        pulse_run();
        wait_halt(200, cyc);
        chk("t5_jz_taken", 32'(pc_out), 32'd4);
        load(4, ii(MOV, 1, 0, 16'd1));
        load(5, ii(JZERO, 0, 0, 16'd3));
        load(6, ii(HALT, 0, 0, 0));
        load(7, ii(HALT, 0, 0, 0));
        pulse_run();
        @(negedge clk);
        imem_we    = 1'b1;
        imem_waddr = 4'd6;
        imem_wdata = ii(MOV, 7, 0, 16'd1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        imem_we    = 1'b0;
        wait_halt(200, cyc);
        chk("t5_jz_not_taken", 32'(pc_out), 32'd7);

        // Test 6: reset during DELAY aborts, program is retained
        do_reset();
        load(0, ii(MOV, 1, 0, 16'd5));
        load(1, ii(ADD, 2, 1, 16'd3));
        load(2, ii(STOREREG, 0, 2, 16'd2));
        load(3, ii(SENDDOUT, 0, 0, 16'd2));
        load(4, ii(HALT, 0, 0, 0));
        load(5, ii(MOV, 6, 0, 16'd0));
        load(6, ii(JUMP, 0, 0, 16'd0));
        exp_q.push_back(16'h0008);
        pulse_run();
        wait_halt(200, cyc);
        chk("t6_first_pc", 32'(pc_out), 32'd5);
        pulse_run();
        repeat (10) @(posedge clk);
        @(negedge clk);
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        chk("t6_rst_pc",     32'(pc_out),    32'd0);
        chk("t6_rst_dout",   32'(dout),      32'h0);
        chk("t6_rst_flags",  32'(flags_out), 32'h0);
        chk("t6_rst_halted", 32'(halted),    32'h0);
        repeat (3) @(negedge clk);
        chk("t6_idle_pc", 32'(pc_out), 32'd0);
        exp_q.push_back(16'h0008);
        pulse_run();
        wait_halt(200, cyc);
        chk("t6_rerun_cycles", 32'(cyc), 32'd35);
        chk("t6_rerun_pc",     32'(pc_out), 32'd5);
        chk("t6_rerun_flags",  32'(flags_out), 32'h0);

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_proc_core.md
Name: param_proc_core

Overview:
Parametrised successor of the team's 16-bit multi-cycle processor core. It keeps the same 32-bit instruction format and opcode map. It adds configurable data width, register count, memory depths and execute delay, plus a program-load port and a run/halt handshake. Flags persist and are updated only by ALU ops, and the PC, flags and output strobe are visible at the ports. It sits between the program loader/testbench and the din/dout data path.

Parameters:
DATA_W, 16, GPR/SGPR/data-memory/din/dout width (16..32)
NGPR, 32, number of GPRs (power of 2, 2..32); register index = low log2(NGPR) bits of the 5-bit field
IMEM_AW, 4, instruction-memory address width (depth 2**IMEM_AW)
DMEM_AW, 4, data-memory address width (depth 2**DMEM_AW)
EXEC_DELAY, 4, extra wait cycles after execute (0..15)

Ports:
clk  in  1  clock, rising edge
sys_rst  in  1  synchronous, active-high reset
run  in  1  start/resume request, sampled in IDLE/HALT
din  in  DATA_W  external data for storedin
imem_we  in  1  program-load write enable
imem_waddr  in  IMEM_AW  program-load address
imem_wdata  in  32  program-load instruction word
dout  out  DATA_W  registered output data
dout_valid  out  1  one-cycle strobe when dout is written
halted  out  1  high while in HALT
pc_out  out  IMEM_AW  current PC
flags_out  out  4  {sign, zero, overflow, carry}

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. sys_rst has priority over all other activity.
- Reset sets: state=IDLE, PC=0, all GPRs, SGPR and IR = 0, flags=0, dout=0, dout_valid=0, halted=0.
- Reset does not clear instruction or data memory. Asserting reset mid-operation aborts the instruction with no further writes.
- Instruction fields: op[31:27], rdst[26:22], rsrc1[21:17], imm[16], rsrc2[15:11], isrc[15:0].
- isrc is zero-extended to DATA_W. Memory addresses use isrc[DMEM_AW-1:0]; jump targets use isrc[IMEM_AW-1:0].
- FSM states: IDLE, FETCH, EXEC, DELAY, NEXT, HALT.
  - IDLE -> FETCH when run=1.
  - FETCH: IR <= imem[PC], 1 cycle.
  - EXEC: register/memory/dout writes, flag update and jump decision, 1 cycle.
  - DELAY: EXEC_DELAY cycles; skipped when EXEC_DELAY=0.
  - NEXT: PC <= jump ? target : PC+1. PC wraps modulo 2**IMEM_AW. Then -> HALT if op=halt, else -> FETCH.
  - HALT: halted=1. run=1 -> FETCH; the PC already points past the halt, so execution resumes there.
- Latency: EXEC_DELAY+3 cycles per instruction.
- imem writes are accepted only in IDLE or HALT and ignored in every other state. A write and a run=1 in the same cycle: the write is applied, then the FSM leaves for FETCH.
- Opcodes: movsgpr 00000 … rnot 01011, storereg 01101, storedin 01110, senddout 01111, sendreg 10001, jumps 10010-11010, halt 11011. The encoding and semantics of each are identical to the existing core.
- Unused opcodes (01100, 10000, 11100-11111) execute as NOP with flags unchanged.
- mul: the full 2*DATA_W-bit product is formed. GPR[rdst] = low half, SGPR = high half.
- senddout: dout <= dmem[addr]; dout_valid=1 for exactly the cycle after EXEC. dout holds its value until the next senddout or reset.
- Flags are registered and updated in EXEC only for ALU ops (00000-01011). All other ops leave flags unchanged.
  - zero = result==0; for mul, zero = full product==0.
  - sign = result MSB; for mul, sign = SGPR MSB.
  - carry = add carry-out, or sub borrow (rsrc1 < operand2 unsigned); 0 for other ALU ops.
  - overflow = signed add/sub overflow at bit DATA_W-1; 0 for other ALU ops.
- Conditional jumps test the flags as they stand at EXEC, i.e. after the previous ALU op.

Test Plan:
1. Load program: mov R1,#5; add R2,R1,#3; storereg dmem[2]<=R2; senddout dmem[2]; halt. Pulse run. -> dout=0x0008 with one dout_valid pulse; halted=1, pc_out=5, flags_out=4'b0000; 35 cycles from FETCH of instr 0 to HALT entry (EXEC_DELAY=4).
2. mov R1,#0xFFFF; add R2,R1,#1. -> flags_out=4'b0101 (zero, carry). Follow with storereg/senddout -> dout=0x0000. A later senddout leaves flags at 4'b0101.
3. mov R1,#0x7FFF; add R2,R1,#1. -> result 0x8000, flags_out=4'b1010. Then sub R3,R1,#0x8000 -> carry=1 (borrow).
4. mov R1,#0x0100; mul R2,R1,#0x0100; movsgpr R3; store/send R3. -> dout=0x0001, R2=0; zero=0 after mul; flags_out=4'b0000 after movsgpr.
5. Program with a non-jump at address 15. -> pc_out wraps to 0. With zero=1, jzero #3 -> pc_out=3; with zero=0 -> PC+1. imem_we pulses during FETCH/EXEC/DELAY leave imem unchanged.
6. Assert sys_rst for 1 cycle during DELAY. -> next cycle: IDLE, pc_out=0, dout=0, flags_out=0, halted=0. Program retained: run=1 re-executes from address 0 with identical results.
